// File: rtl/store_pkg.sv
// Shared encodings and helpers for the MEM-stage store sequencer.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 6;

  localparam logic [SEL_W-1:0] SEL_SB = 6'b010000;
  localparam logic [SEL_W-1:0] SEL_SH = 6'b010001;
  localparam logic [SEL_W-1:0] SEL_SW = 6'b010010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  // Store size in bytes; 0 marks an illegal select.
  function automatic logic [2:0] size_of(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL_SB:  size_of = 3'd1;
      SEL_SH:  size_of = 3'd2;
      SEL_SW:  size_of = 3'd4;
      default: size_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places right-justified store data into a two-word lane space and builds
// the matching byte enables; split flags a store that spills into word+1.
module store_lane_align
  import store_pkg::*;
(
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [1:0]        off_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [63:0]       d64_o,
  output logic [7:0]        be64_o,
  output logic              split_o
);

  logic [2:0]        size;
  logic [DATA_W-1:0] mask;
  logic [7:0]        be_base;

  always_comb begin
    size    = size_of(sel_i);
    mask    = '0;
    be_base = '0;
    case (size)
      3'd1: begin mask = 32'h0000_00FF; be_base = 8'h01; end
      3'd2: begin mask = 32'h0000_FFFF; be_base = 8'h03; end
      3'd4: begin mask = 32'hFFFF_FFFF; be_base = 8'h0F; end
      default: ;
    endcase
    d64_o   = {32'h0, data_i & mask} << {off_i, 3'b000};
    be64_o  = be_base << off_i;
    split_o = |be64_o[7:4];
  end

endmodule

// File: rtl/store_access_sequencer.sv
// Accepts one store at a time and drives it to data memory as one or two
// aligned, handshaked write beats while stalling the pipeline.
module store_access_sequencer
  import store_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_W-1:0]      req_aluSelect,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  output logic                  stall,
  output logic                  done,
  output logic                  err_illegal
);

  logic [63:0] d64;
  logic [7:0]  be64;
  logic        split;

  store_lane_align u_align (
    .sel_i   (req_aluSelect),
    .off_i   (req_addr[1:0]),
    .data_i  (req_data),
    .d64_o   (d64),
    .be64_o  (be64),
    .split_o (split)
  );

  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  stall_q, stall_d;
  logic                  ready_q, ready_d;
  logic                  split_q, split_d;
  logic [3:0]            hi_be_q, hi_be_d;
  logic [DATA_W-1:0]     hi_wdata_q, hi_wdata_d;

  logic accept;
  logic legal;
  logic finish;

  assign accept = req_valid & ready_q;
  assign legal  = (size_of(req_aluSelect) != 3'd0);

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    stall_d    = stall_q;
    ready_d    = ready_q;
    split_d    = split_q;
    hi_be_d    = hi_be_q;
    hi_wdata_d = hi_wdata_q;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d    = BEAT0;
            wr_en_d    = 1'b1;
            addr_d     = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            be_d       = be64[3:0];
            wdata_d    = d64[31:0];
            split_d    = split;
            hi_be_d    = be64[7:4];
            hi_wdata_d = d64[63:32];
            stall_d    = 1'b1;
            ready_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          if (split_q) begin
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_WIDTH'(4);
            be_d    = hi_be_q;
            wdata_d = hi_wdata_q;
          end else begin
            finish = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
      done_d  = 1'b1;
      stall_d = 1'b0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      ready_q    <= 1'b1;
      split_q    <= 1'b0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      done_q     <= done_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      ready_q    <= ready_d;
      split_q    <= split_d;
      hi_be_q    <= hi_be_d;
      hi_wdata_q <= hi_wdata_d;
    end
  end

  assign req_ready   = ready_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign stall       = stall_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_store_access_sequencer.sv
// Scoreboard bench for store_access_sequencer: a byte-level store model feeds
// an expected-event queue that a monitor drains against the memory port.
module tb_store_access_sequencer;

  localparam logic [5:0] T_SB = 6'b010000;
  localparam logic [5:0] T_SH = 6'b010001;
  localparam logic [5:0] T_SW = 6'b010010;

  localparam int K_BEAT = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_aluSelect = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        done;
  logic        err_illegal;

  store_access_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_aluSelect (req_aluSelect),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .stall         (stall),
    .done          (done),
    .err_illegal   (err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  ack_delay = -1;
  int  ack_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory-side ack: random, or a fixed number of wait cycles per beat.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (ack_delay < 0) mem_ack = ($urandom_range(0, 2) == 0);
      else               mem_ack = (ack_cnt >= ack_delay);
      if (mem_ack) ack_cnt = 0;
      else         ack_cnt++;
    end else begin
      mem_ack = (ack_delay < 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      ack_cnt = 0;
    end
  end

  // Reference model: place each stored byte at its own byte address.
  task automatic model_push(input logic [5:0] sel, input logic [31:0] addr, input logic [31:0] data);
    int n;
    logic [31:0] base, a, w0, w1;
    logic [3:0]  be0, be1;
    ev_t e;
    case (sel)
      T_SB: n = 1;
      T_SH: n = 2;
      T_SW: n = 4;
      default: n = 0;
    endcase
    if (n == 0) begin
      e = '{K_ERR, 32'h0, 4'h0, 32'h0};
      exp_q.push_back(e);
    end else begin
      base = addr & ~32'h3;
      w0 = '0; w1 = '0; be0 = '0; be1 = '0;
      for (int k = 0; k < n; k++) begin
        int ln;
        a  = addr + 32'(k);
        ln = int'(a[1:0]);
        if ((a & ~32'h3) == base) begin
          be0[ln] = 1'b1;
          w0[8*ln +: 8] = data[8*k +: 8];
        end else begin
          be1[ln] = 1'b1;
          w1[8*ln +: 8] = data[8*k +: 8];
        end
      end
      e = '{K_BEAT, base, be0, w0};
      exp_q.push_back(e);
      if (be1 != 4'h0) begin
        e = '{K_BEAT, base + 32'd4, be1, w1};
        exp_q.push_back(e);
      end
      e = '{K_DONE, 32'h0, 4'h0, 32'h0};
      exp_q.push_back(e);
    end
  endtask

  task automatic pop_expect(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{-1, 32'h0, 4'h0, 32'h0};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: compares every accepted beat, done and error pulse.
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    #1;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && mem_wr_en) begin
        check("hold_addr",  mem_addr,  prev_addr);
        check("hold_be",    32'(mem_be), 32'(prev_be));
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_wr_en && mem_ack) begin
        pop_expect(K_BEAT, e, ok);
        if (ok) begin
          check("beat_addr",  mem_addr,  e.addr);
          check("beat_be",    32'(mem_be), 32'(e.be));
          check("beat_wdata", mem_wdata, e.wdata);
        end
      end
      if (done)        pop_expect(K_DONE, e, ok);
      if (err_illegal) pop_expect(K_ERR, e, ok);
      prev_hold  = mem_wr_en && !mem_ack;
      prev_addr  = mem_addr;
      prev_be    = mem_be;
      prev_wdata = mem_wdata;
    end
  end

  // Present one request when the sequencer is ready; returns the accept cycle.
  task automatic issue(input logic [5:0] sel, input logic [31:0] addr,
                       input logic [31:0] data, output int acc);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1 (cycle %0d)", cyc);
    end
    req_valid     = 1'b1;
    req_aluSelect = sel;
    req_addr      = addr;
    req_data      = data;
    model_push(sel, addr, data);
    acc = cyc;
    @(negedge clk);
    req_valid     = 1'b0;
    req_aluSelect = 6'h3F;
  endtask

  task automatic wait_done(input string name, input int acc, input int lat);
    int guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check(name, 32'(cyc - acc), 32'(lat));
  endtask

  initial begin
    int acc;
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [5:0] sel;
    int guard;

    // Reset state
    #12;
    check("rst_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_be",    32'(mem_be), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_err",   32'(err_illegal), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'h1);

    // SB at offset 3, immediate ack
    ack_delay = 0;
    issue(T_SB, 32'h0000_1003, 32'hDEAD_BEEF, acc);
    check("sb_stall", 32'(stall), 32'h1);
    check("sb_ready", 32'(req_ready), 32'h0);
    wait_done("sb_latency", acc, 2);
    check("sb_ready_done", 32'(req_ready), 32'h1);

    // SH at offset 2, three wait cycles
    ack_delay = 3;
    issue(T_SH, 32'h0000_2002, 32'hCAFE_BABE, acc);
    wait_done("sh_latency", acc, 5);

    // SW split across two words
    ack_delay = 0;
    issue(T_SW, 32'h0000_3001, 32'h1234_5678, acc);
    wait_done("sw_split_latency", acc, 3);

    // SW split wrapping the address space
    issue(T_SW, 32'hFFFF_FFFE, 32'hAABB_CCDD, acc);
    wait_done("sw_wrap_latency", acc, 3);

    // Illegal select
    issue(6'b000000, 32'h0000_5000, 32'h0102_0304, acc);
    check("ill_err",   32'(err_illegal), 32'h1);
    check("ill_wr_en", 32'(mem_wr_en), 32'h0);
    check("ill_ready", 32'(req_ready), 32'h1);
    check("ill_stall", 32'(stall), 32'h0);

    // Reset while the second beat waits for ack
    issue(T_SW, 32'h0000_4001, 32'h5566_7788, acc);
    @(posedge clk);
    #1;
    ack_delay = 1000;
    @(negedge clk);
    @(negedge clk);
    check("b1_wr_en_pending", 32'(mem_wr_en), 32'h1);
    check("b1_addr_pending",  mem_addr, 32'h0000_4004);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(mem_wr_en), 32'h0);
    check("arst_addr",  mem_addr, 32'h0);
    check("arst_be",    32'(mem_be), 32'h0);
    check("arst_wdata", mem_wdata, 32'h0);
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_done",  32'(done), 32'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(mem_wr_en), 32'h0);
    end
    ack_delay = 0;
    issue(T_SB, 32'h0000_6002, 32'h0000_00A5, acc);
    wait_done("post_rst_sb_latency", acc, 2);

    // Randomized back-to-back traffic with random acks
    ack_delay = -1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    sel = T_SB;
        2, 3:    sel = T_SH;
        4, 5, 6: sel = T_SW;
        default: sel = 6'($urandom);
      endcase
      issue(sel, $urandom, $urandom, acc);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_access_sequencer.md
# store_access_sequencer

Sequences data-memory writes for the MEM stage of the pipelined RV32 core. It accepts one store request at a time (SB/SH/SW, selected by the 6-bit `aluSelect` code), aligns data into byte lanes, and generates byte enables. A store that crosses a word boundary is split into two aligned write beats. It drives a handshaked, multi-cycle data-memory write port and stalls the pipeline until the store completes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width; the data path is fixed at 32 bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage presents a store.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_aluSelect`  in  6  store type: SB=6'b010000, SH=6'b010001, SW=6'b010010; any other value is illegal.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_data`  in  32  store data, right-justified.
- `mem_wr_en`  out  1  write request to data memory; held until acknowledged.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_be`  out  4  byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_ack`  in  1  memory accepted the current beat.
- `stall`  out  1  high whenever not IDLE; holds the pipeline.
- `done`  out  1  one-cycle pulse: store fully written.
- `err_illegal`  out  1  one-cycle pulse: illegal `aluSelect` accepted and discarded.

## Operation
- States: IDLE, BEAT0, BEAT1.
- Size n = 1, 2 or 4 bytes for SB, SH or SW. Offset o = `req_addr[1:0]`.
- Alignment is computed in a 64-bit lane space:
  - d64 = zero-extended masked data << 8·o, where the mask keeps the low n bytes of `req_data`.
  - be64 = ((1<<n)−1) << o.
- Acceptance: `req_valid & req_ready` at a rising edge. All outputs below are registered.
- IDLE → BEAT0 on a legal accept. Outputs:
  - `mem_addr` = `req_addr` & ~3
  - `mem_be` = be64[3:0]
  - `mem_wdata` = d64[31:0]
  - `mem_wr_en` = 1
  - beat-1 values are latched at the same time.
- IDLE stays IDLE on an illegal accept: no memory access, `err_illegal` pulses the next cycle.
- BEAT0 with `mem_ack`:
  - If be64[7:4] ≠ 0, go to BEAT1 with `mem_addr` = base+4 (wraps modulo 2^ADDR_WIDTH), `mem_be` = be64[7:4], `mem_wdata` = d64[63:32].
  - Otherwise go to IDLE, drop `mem_wr_en`, pulse `done`.
- BEAT1 with `mem_ack`: go to IDLE, drop `mem_wr_en`, pulse `done`.
- Without `mem_ack`, all `mem_*` outputs hold stable. There is no timeout.
- `mem_ack` while `mem_wr_en` = 0 is ignored.
- Disabled lanes of `mem_wdata` are driven to 0.
- Split cases: SH at o = 3; SW at o = 1, 2 or 3. All other cases are a single beat.
- Reset (asynchronous, any state):
  - state → IDLE.
  - `mem_wr_en`, `mem_be`, `mem_addr`, `mem_wdata`, `done`, `err_illegal`, `stall` → 0.
  - `req_ready` → 1 after reset deasserts.
  - An in-flight store, including a pending second beat, is abandoned.

## Timing
- Accept at edge N → `mem_wr_en` = 1 during cycle N+1.
- Single beat, ack in N+1 → `done` and `req_ready` high in cycle N+2.
- Two beats, acks in N+1 and N+2 → `done` in cycle N+3.
- Each wait cycle without `mem_ack` adds one cycle.
- Back-to-back stores: the next accept can occur at the edge ending the `done` cycle.
- Illegal select: accept at N → `err_illegal` in N+1, `req_ready` stays high.
- `stall` = !IDLE. It is registered and asserts in cycle N+1.

## Structure
- Package `store_pkg`:
  - localparams SEL_SB, SEL_SH, SEL_SW;
  - state enum IDLE/BEAT0/BEAT1;
  - function size_of(sel) returning n, with 0 for illegal.
- Sub-module `store_lane_align`: combinational (sel, addr[1:0], data) → d64, be64, split flag.
- The FSM and output registers live in the top module.

## Test plan
- SB, addr 0x1003, data 0xDEADBEEF, ack immediately → one beat: addr 0x1000, be 4'b1000, wdata 0xEF000000; `done` at N+2.
- SH, addr 0x2002, data 0xCAFEBABE, ack delayed 3 cycles → addr 0x2000, be 4'b1100, wdata 0xBABE0000 held stable; `done` at N+5.
- SW, addr 0x3001, data 0x12345678 → beat 0: addr 0x3000, be 4'b1110, wdata 0x34567800; beat 1: addr 0x3004, be 4'b0001, wdata 0x00000012; `done` at N+3.
- SW, addr 0xFFFFFFFE, data 0xAABBCCDD → beat 1 addr wraps to 0x00000000, be 4'b0011, wdata 0x0000AABB.
- `aluSelect` 6'b000000 → `err_illegal` pulse, no `mem_wr_en`, `req_ready` stays 1.
- `reset_n` low during BEAT1 wait → all outputs 0 immediately, no second beat after release, next SB completes normally.
